// File: rtl/cnt_sweep_pkg.sv
// Shared types and default sizes for the triangular sweep controller.
package cnt_sweep_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_REP_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_DONE
  } state_t;

endpackage

// File: rtl/cnt_sweep_ctrl_updown_cnt_core.sv
// Loadable up/down counter: load has priority over en, up selects direction.
module updown_cnt_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  // Counter register: load, else step by one in the selected direction, else hold.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (en) begin
      q <= up ? q + 1'b1 : q - 1'b1;
    end
  end

endmodule

// File: rtl/cnt_sweep_ctrl.sv
// Sequences an up/down counter through lo->hi->lo sweeps, a commanded number of times.
module cnt_sweep_ctrl
  import cnt_sweep_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned REP_W = DEF_REP_W
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_lo,
  input  logic [WIDTH-1:0] cmd_hi,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lo_r, hi_r;
  logic [REP_W-1:0] reps_left;
  logic             err_r;
  logic             cnt_load, cnt_en;
  logic [WIDTH-1:0] cnt_inc, cnt_dec;
  logic             accept, bad_cmd, sweep_end, abort_act;

  assign accept    = (state == S_IDLE) && cmd_valid;
  assign bad_cmd   = cmd_lo > cmd_hi;
  assign cnt_inc   = count + 1'b1;
  assign cnt_dec   = count - 1'b1;
  assign sweep_end = (state == S_DOWN) && (cnt_dec == lo_r);
  assign abort_act = abort && (state != S_IDLE);

  updown_cnt_core #(.WIDTH(WIDTH)) u_core (
    .clock (clock),
    .rst   (rst),
    .load  (cnt_load),
    .en    (cnt_en),
    .up    (state == S_UP),
    .din   (lo_r),
    .q     (count)
  );

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and counter controls; abort overrides everything outside IDLE.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      S_IDLE: if (accept && !bad_cmd) state_nxt = S_LOAD;
      S_LOAD: begin
        cnt_load  = 1'b1;
        state_nxt = (lo_r == hi_r) ? S_DONE : S_UP;
      end
      S_UP: begin
        cnt_en = 1'b1;
        if (cnt_inc == hi_r) state_nxt = S_DOWN;
      end
      S_DOWN: begin
        cnt_en = 1'b1;
        if (sweep_end) state_nxt = (reps_left == REP_ONE) ? S_DONE : S_UP;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_act) begin
      state_nxt = S_IDLE;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
    end
  end

  // Command capture, repetition bookkeeping and the rejected-command pulse.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      lo_r      <= '0;
      hi_r      <= '0;
      reps_left <= '0;
      err_r     <= 1'b0;
    end else begin
      err_r <= accept && bad_cmd;
      if (accept && !bad_cmd) begin
        lo_r      <= cmd_lo;
        hi_r      <= cmd_hi;
        reps_left <= (cmd_reps == '0) ? REP_ONE : cmd_reps;
      end else if (abort_act) begin
        reps_left <= '0;
      end else if (sweep_end) begin
        reps_left <= reps_left - 1'b1;
      end
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dir       = (state == S_UP);
  assign done      = (state == S_DONE);
  assign err       = err_r;

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// Scoreboard bench for cnt_sweep_ctrl: the driver predicts the per-cycle trace of
// each command from the sweep path; the monitor pops and compares on every
// cycle in which the DUT shows activity (busy, done or err).
module tb_cnt_sweep_ctrl;

  typedef struct {
    int   cnt;
    logic dir;
    logic busy;
    logic done;
    logic err;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_lo = '0, cmd_hi = '0, cmd_reps = '0;
  logic       abort = 1'b0;
  logic [3:0] count;
  logic       dir, busy, done, err;

  int   tests = 0;
  int   fails = 0;
  int   last_count = 0;
  exp_t q[$];

  cnt_sweep_ctrl #(.WIDTH(4), .REP_W(4)) dut (
    .clock     (clock),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_lo    (cmd_lo),
    .cmd_hi    (cmd_hi),
    .cmd_reps  (cmd_reps),
    .abort     (abort),
    .count     (count),
    .dir       (dir),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  // Monitor: handshake sanity every cycle, scoreboard pop on visible activity.
  always @(negedge clock) begin
    if (!rst) begin
      tests++;
      if (cmd_ready !== !busy) begin
        fails++;
        $display("FAIL ready_vs_busy: cmd_ready=%b busy=%b expected cmd_ready=%b", cmd_ready, busy, !busy);
      end
      if (busy || done || err) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_activity: count=%0d dir=%b busy=%b done=%b err=%b with nothing expected",
                   count, dir, busy, done, err);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (count !== 4'(e.cnt) || dir !== e.dir || busy !== e.busy || done !== e.done || err !== e.err) begin
            fails++;
            $display("FAIL trace: got count=%0d dir=%b busy=%b done=%b err=%b expected count=%0d dir=%b busy=%b done=%b err=%b",
                     count, dir, busy, done, err, e.cnt, e.dir, e.busy, e.done, e.err);
          end
        end
      end
    end
  end

  // Checks the values that an asynchronous reset must force with no clock edge.
  task automatic check_reset_values(input string tag);
    tests++;
    if (count !== 4'd0 || dir !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s: count=%0d dir=%b busy=%b done=%b err=%b ready=%b expected 0 0 0 0 0 1",
               tag, count, dir, busy, done, err, cmd_ready);
    end
  endtask

  // Issues one command. ai: cycle index (0 = load cycle) at which abort is raised, -1 for none.
  // rst_at: cycle index at which reset is pulsed mid-operation, -1 for none.
  task automatic run_cmd(input int lo, input int hi, input int reps, input int ai, input int rst_at);
    exp_t tr[$];
    int   vals[$];
    int   n, wait_cnt;
    wait_cnt = 0;
    cmd_valid = 1'b1;
    while (!cmd_ready) begin
      @(negedge clock);
      cmd_lo = 4'($urandom); cmd_hi = 4'($urandom); cmd_reps = 4'($urandom);
      wait_cnt++;
      if (wait_cnt > 2000) begin
        tests++; fails++;
        $display("FAIL ready_timeout: cmd_ready=%b after %0d cycles expected 1", cmd_ready, wait_cnt);
        cmd_valid = 1'b0;
        return;
      end
    end
    cmd_lo   = 4'(lo);
    cmd_hi   = 4'(hi);
    cmd_reps = 4'(reps);
    abort    = ($urandom_range(0, 3) == 0);
    if (lo > hi) begin
      q.push_back('{last_count, 1'b0, 1'b0, 1'b0, 1'b1});
      n = 0;
    end else begin
      int r;
      r = (reps == 0) ? 1 : reps;
      vals.push_back(lo);
      for (int k = 0; k < r; k++) begin
        for (int v = lo + 1; v <= hi; v++) vals.push_back(v);
        for (int v = hi - 1; v >= lo; v--) vals.push_back(v);
      end
      tr.push_back('{last_count, 1'b0, 1'b1, 1'b0, 1'b0});
      for (int i = 0; i < vals.size(); i++) begin
        exp_t e;
        e.cnt  = vals[i];
        e.dir  = (i + 1 < vals.size()) && (vals[i+1] > vals[i]);
        e.busy = 1'b1;
        e.done = (i == vals.size() - 1);
        e.err  = 1'b0;
        tr.push_back(e);
      end
      if (ai >= 0 && ai < tr.size()) begin
        while (tr.size() > ai + 1) void'(tr.pop_back());
      end
      n = tr.size();
      last_count = tr[n-1].cnt;
      foreach (tr[i]) q.push_back(tr[i]);
    end
    for (int j = 0; j < n; j++) begin
      @(negedge clock);
      abort     = (j == ai);
      cmd_valid = $urandom_range(0, 1);
      cmd_lo = 4'($urandom); cmd_hi = 4'($urandom); cmd_reps = 4'($urandom);
      if (j == rst_at) begin
        #2 rst = 1'b1;
        #1 check_reset_values("reset_mid_op");
        q.delete();
        last_count = 0;
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        @(negedge clock);
        #2 rst = 1'b0;
        break;
      end
    end
    @(negedge clock);
    abort     = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #1 check_reset_values("reset_initial");
    @(negedge clock);
    #2 rst = 1'b0;

    run_cmd(2, 4, 1, -1, -1);
    run_cmd(0, 15, 2, -1, -1);
    run_cmd(5, 5, 3, -1, -1);
    run_cmd(9, 3, 1, -1, -1);
    run_cmd(1, 6, 1, 9, -1);      // abort while counting down at 3
    run_cmd(3, 7, 0, -1, -1);
    run_cmd(0, 15, 1, -1, 12);    // reset during the up-ramp
    run_cmd(4, 8, 2, -1, -1);
    for (int i = 0; i < 30; i++) begin
      int lo, hi, rp, ai;
      lo = $urandom_range(0, 15);
      hi = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(lo, 15);
      rp = $urandom_range(0, 4);
      ai = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
      run_cmd(lo, hi, rp, ai, -1);
    end

    repeat (3) @(negedge clock);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expected: %0d entries still pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
